// File: rtl/packet_buffer_read_arbiter.sv
// packet_buffer_read_arbiter
// This block shares the single read port of the packet buffer RAM driver between two requesters.
// Requester 0 is the tx serializer. Requester 1 is the checksum/crypto engine.
// Each cycle at most one read is granted, using round-robin priority.
// Every issued read is tagged with the id of the requester that issued it.
// The tag travels down a pipeline that matches the driver read latency.
// The returned byte is steered to that requester only, through one register stage.
// tag_err is sticky. It latches any cycle where ram_outclk disagrees with the tag pipeline.
//
// Optional build macro PACKET_BUFFER_ARB_BURST_EN adds burst locking.
// A transfer with reqN_last==0 locks the grant to requester N until N transfers with last==1.
// Without the macro, req*_last is ignored and arbitration happens per transfer.
module packet_buffer_read_arbiter #(
   parameter int PACKET_BUFFER_SIZE         = 256,
   parameter int PACKET_BUFFER_READ_LATENCY = 2,
   parameter int RAM_SIZE                   = PACKET_BUFFER_SIZE,
   parameter int READ_LATENCY               = PACKET_BUFFER_READ_LATENCY,
   parameter int BYTE_LEN                   = 8,
   localparam int ADDR_W                    = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req0_valid,
   input  logic [ADDR_W-1:0]   req0_addr,
   input  logic                req0_last,
   output logic                req0_ready,
   output logic                req0_outclk,
   output logic [BYTE_LEN-1:0] req0_out,
   input  logic                req1_valid,
   input  logic [ADDR_W-1:0]   req1_addr,
   input  logic                req1_last,
   output logic                req1_ready,
   output logic                req1_outclk,
   output logic [BYTE_LEN-1:0] req1_out,
   output logic                ram_readclk,
   output logic [ADDR_W-1:0]   ram_raddr,
   input  logic                ram_outclk,
   input  logic [BYTE_LEN-1:0] ram_out,
   output logic                tag_err
);

   // Priority register: 1 means requester 1 was granted most recently.
   logic                    last_gnt_q, last_gnt_d;
   logic                    lock_s, lock_id_s;
   logic                    gnt0_s, gnt1_s, xfer_s;
   logic [READ_LATENCY-1:0] tag_vld_q, tag_vld_d;
   logic [READ_LATENCY-1:0] tag_id_q, tag_id_d;
   logic                    tail_vld_s, tail_id_s;
   logic                    oc0_q, oc0_d, oc1_q, oc1_d;
   logic [BYTE_LEN-1:0]     out0_q, out0_d, out1_q, out1_d;
   logic                    err_q, err_d;

`ifdef PACKET_BUFFER_ARB_BURST_EN
   logic lock_q, lock_d, lock_id_q, lock_id_d;

   // Burst lock: a non-final transfer pins the grant, and the final transfer releases it.
   always_comb begin
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      if (xfer_s) begin
         lock_id_d = gnt1_s;
         lock_d    = gnt1_s ? ~req1_last : ~req0_last;
      end else begin
         lock_d    = lock_q;
         lock_id_d = lock_id_q;
      end
   end

   // Burst lock registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         lock_q    <= 1'b0;
         lock_id_q <= 1'b0;
      end else begin
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
      end
   end

   assign lock_s    = lock_q;
   assign lock_id_s = lock_id_q;
`else
   logic unused_last_s;
   assign unused_last_s = req0_last ^ req1_last;
   assign lock_s        = 1'b0;
   assign lock_id_s     = 1'b0;
`endif

   // Grant selection: a held lock wins first, then round-robin on contention, else whoever is valid.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (!rst) begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end else if (lock_s) begin
         gnt0_s = req0_valid & ~lock_id_s;
         gnt1_s = req1_valid &  lock_id_s;
      end else if (req0_valid && req1_valid) begin
         gnt0_s = last_gnt_q;
         gnt1_s = ~last_gnt_q;
      end else begin
         gnt0_s = req0_valid;
         gnt1_s = req1_valid;
      end
   end

   assign xfer_s      = gnt0_s | gnt1_s;
   assign req0_ready  = gnt0_s;
   assign req1_ready  = gnt1_s;
   assign ram_readclk = xfer_s;
   assign ram_raddr   = gnt0_s ? req0_addr : (gnt1_s ? req1_addr : {ADDR_W{1'b0}});

   assign tail_vld_s  = tag_vld_q[READ_LATENCY-1];
   assign tail_id_s   = tag_id_q[READ_LATENCY-1];

   // Next state: priority update, tag shift, steered return, and sticky tag check.
   always_comb begin
      last_gnt_d = last_gnt_q;
      tag_vld_d  = '0;
      tag_id_d   = '0;
      if (xfer_s) begin
         last_gnt_d = gnt1_s;
      end else begin
         last_gnt_d = last_gnt_q;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_id_d[i]  = tag_id_q[i-1];
      end
      tag_vld_d[0] = xfer_s;
      tag_id_d[0]  = gnt1_s;
      oc0_d  = ram_outclk & tail_vld_s & ~tail_id_s;
      oc1_d  = ram_outclk & tail_vld_s &  tail_id_s;
      out0_d = oc0_d ? ram_out : out0_q;
      out1_d = oc1_d ? ram_out : out1_q;
      err_d  = err_q | (ram_outclk ^ tail_vld_s);
   end

   // State registers, with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last_gnt_q <= 1'b1;
         tag_vld_q  <= '0;
         tag_id_q   <= '0;
         oc0_q      <= 1'b0;
         oc1_q      <= 1'b0;
         out0_q     <= {BYTE_LEN{1'b0}};
         out1_q     <= {BYTE_LEN{1'b0}};
         err_q      <= 1'b0;
      end else begin
         last_gnt_q <= last_gnt_d;
         tag_vld_q  <= tag_vld_d;
         tag_id_q   <= tag_id_d;
         oc0_q      <= oc0_d;
         oc1_q      <= oc1_d;
         out0_q     <= out0_d;
         out1_q     <= out1_d;
         err_q      <= err_d;
      end
   end

   assign req0_outclk = oc0_q;
   assign req1_outclk = oc1_q;
   assign req0_out    = out0_q;
   assign req1_out    = out1_q;
   assign tag_err     = err_q;

endmodule
